// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_isa_pkg : opcodes, register codes and harness state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package mips_isa_pkg;

    localparam int ISA_DATA_W = 16;
    localparam int ISA_OP_W   = 5;

    localparam logic [ISA_OP_W-1:0] OP_NOP   = 5'b00001;
    localparam logic [ISA_OP_W-1:0] OP_JUMP  = 5'b00010;
    localparam logic [ISA_OP_W-1:0] OP_LOAD  = 5'b10001;
    localparam logic [ISA_OP_W-1:0] OP_STORE = 5'b10010;
    localparam logic [ISA_OP_W-1:0] OP_ADDI  = 5'b10011;
    localparam logic [ISA_OP_W-1:0] OP_HALT  = 5'b11011;

    localparam logic [2:0] REG_S0 = 3'd0;
    localparam logic [2:0] REG_S1 = 3'd1;
    localparam logic [2:0] REG_S2 = 3'd2;
    localparam logic [2:0] REG_S3 = 3'd3;
    localparam logic [2:0] REG_S4 = 3'd4;
    localparam logic [2:0] REG_S5 = 3'd5;
    localparam logic [2:0] REG_S6 = 3'd6;
    localparam logic [2:0] REG_S7 = 3'd7;

    localparam logic [ISA_DATA_W-1:0] ISA_NOP_WORD = 16'h0800;

    typedef enum logic [2:0] {
        HS_IDLE    = 3'd0,
        HS_PRESET  = 3'd1,
        HS_RUN     = 3'd2,
        HS_HALTED  = 3'd3,
        HS_TIMEOUT = 3'd4
    } hstate_e;

    localparam logic [1:0] ST_CODE_IDLE    = 2'b00;
    localparam logic [1:0] ST_CODE_RUN     = 2'b01;
    localparam logic [1:0] ST_CODE_HALTED  = 2'b10;
    localparam logic [1:0] ST_CODE_TIMEOUT = 2'b11;

    // PRESET is reported as RUN so the host sees a single "busy" code.
    function automatic logic [1:0] state_code(input hstate_e s);
        logic [1:0] code;
        case (s)
            HS_PRESET, HS_RUN: code = ST_CODE_RUN;
            HS_HALTED:         code = ST_CODE_HALTED;
            HS_TIMEOUT:        code = ST_CODE_TIMEOUT;
            default:           code = ST_CODE_IDLE;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/harness_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// harness_ram : 1 sync write port, 1 combinational read, 1 registered read
// Rev 1.0
// ---------------------------------------------------------------------------
module harness_ram #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_b_q;

    // Array contents are deliberately left unreset so they survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_b_q <= '0;
        end else begin
            rdata_b_q <= mem_q[raddr_b];
        end
    end

    assign rdata_b = rdata_b_q;

endmodule
`default_nettype wire

// File: rtl/mips_run_harness.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_run_harness : run control, instruction/data RAMs and dump port
// Rev 1.0
// ---------------------------------------------------------------------------
module mips_run_harness
    import mips_isa_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                PC_W       = 8,
    parameter int                IMEM_AW    = 8,
    parameter int                DMEM_AW    = 8,
    parameter int                OP_W       = 5,
    parameter logic [OP_W-1:0]   HALT_OP    = OP_HALT,
    parameter logic [DATA_W-1:0] NOP_WORD   = ISA_NOP_WORD,
    parameter int                PRESET_CYC = 2,
    parameter int                MAX_CYCLES = 1024,
    parameter int                CNT_W      = 16,
    localparam int               LD_AW      = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic               ld_sel,
    input  logic [LD_AW-1:0]   ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    input  logic               start,
    input  logic               clr,
    output logic               cpu_reset,
    input  logic [PC_W-1:0]    pc,
    output logic [DATA_W-1:0]  instr,
    input  logic               memwrite,
    input  logic [DATA_W-1:0]  writedata,
    input  logic [DATA_W-1:0]  aluout,
    output logic [DATA_W-1:0]  readdata,
    input  logic [DMEM_AW-1:0] dump_addr,
    output logic [DATA_W-1:0]  dump_data,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   cycles
);

    localparam int               PRE_W    = (PRESET_CYC > 1) ? $clog2(PRESET_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESET_CYC - 1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);

    hstate_e            state_q, state_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [PRE_W-1:0]   pre_q, pre_d;

    logic               running;
    logic               is_halt;
    logic               ld_fire;
    logic [DATA_W-1:0]  imem_rd;
    logic [DATA_W-1:0]  imem_unused_rd;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_waddr;
    logic [DATA_W-1:0]  dmem_wdata;

    // High address bits are dropped on purpose (addresses wrap).
    logic [PC_W-1:0]    pc_unused;
    logic [DATA_W-1:0]  aluout_unused;
    logic [LD_AW-1:0]   ld_addr_unused;
    assign pc_unused      = pc;
    assign aluout_unused  = aluout;
    assign ld_addr_unused = ld_addr;

    assign running   = (state_q == HS_RUN);
    assign cpu_reset = (state_q == HS_IDLE) || (state_q == HS_PRESET);
    assign ld_ready  = (state_q == HS_IDLE) || (state_q == HS_HALTED) ||
                       (state_q == HS_TIMEOUT);
    assign ld_fire   = ld_valid && ld_ready;
    assign instr     = running ? imem_rd : NOP_WORD;
    assign is_halt   = running && (imem_rd[DATA_W-1 -: OP_W] == HALT_OP);
    assign state     = state_code(state_q);
    assign cycles    = cyc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HS_IDLE;
            cyc_q   <= '0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        pre_d   = pre_q;
        case (state_q)
            HS_IDLE: begin
                if (start) begin
                    state_d = HS_PRESET;
                    cyc_d   = '0;
                    pre_d   = '0;
                end
            end
            HS_PRESET: begin
                if (pre_q == PRE_LAST) begin
                    state_d = HS_RUN;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            HS_RUN: begin
                if (cyc_q != '1) begin
                    cyc_d = cyc_q + 1'b1;
                end
                // HALT outranks the watchdog when both land on the same cycle.
                if (is_halt) begin
                    state_d = HS_HALTED;
                end else if (cyc_q == CYC_LAST) begin
                    state_d = HS_TIMEOUT;
                end
            end
            HS_HALTED, HS_TIMEOUT: begin
                if (start) begin
                    state_d = HS_PRESET;
                    cyc_d   = '0;
                    pre_d   = '0;
                end else if (clr) begin
                    state_d = HS_IDLE;
                end
            end
            default: begin
                state_d = HS_IDLE;
            end
        endcase
    end

    // The loader is only ready outside RUN, so the two data RAM writers never collide.
    assign dmem_we    = (ld_fire && ld_sel) || (running && memwrite);
    assign dmem_waddr = running ? aluout[DMEM_AW-1:0] : ld_addr[DMEM_AW-1:0];
    assign dmem_wdata = running ? writedata : ld_data;

    harness_ram #(
        .AW (IMEM_AW),
        .DW (DATA_W)
    ) u_imem (
        .clk     (clk),
        .rst_n   (reset),
        .we      (ld_fire && !ld_sel),
        .waddr   (ld_addr[IMEM_AW-1:0]),
        .wdata   (ld_data),
        .raddr_a (pc[IMEM_AW-1:0]),
        .rdata_a (imem_rd),
        .raddr_b ('0),
        .rdata_b (imem_unused_rd)
    );

    harness_ram #(
        .AW (DMEM_AW),
        .DW (DATA_W)
    ) u_dmem (
        .clk     (clk),
        .rst_n   (reset),
        .we      (dmem_we),
        .waddr   (dmem_waddr),
        .wdata   (dmem_wdata),
        .raddr_a (aluout[DMEM_AW-1:0]),
        .rdata_a (readdata),
        .raddr_b (dump_addr),
        .rdata_b (dump_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_mips_run_harness.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_run_harness : randomized bench with a toy core and an ISA-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mips_run_harness;

    localparam int MAXC   = 16;
    localparam int PRESET = 2;

    localparam logic [4:0] T_JUMP  = 5'b00010;
    localparam logic [4:0] T_LOAD  = 5'b10001;
    localparam logic [4:0] T_STORE = 5'b10010;
    localparam logic [4:0] T_ADDI  = 5'b10011;
    localparam logic [4:0] T_HALT  = 5'b11011;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid, ld_ready, ld_sel;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        start, clr, cpu_reset;
    logic [7:0]  pc;
    logic [15:0] instr, writedata, aluout, readdata;
    logic        memwrite;
    logic [7:0]  dump_addr;
    logic [15:0] dump_data;
    logic [1:0]  state;
    logic [15:0] cycles;

    always #5 clk = ~clk;

    mips_run_harness #(.MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data), .start(start),
        .clr(clr), .cpu_reset(cpu_reset), .pc(pc), .instr(instr),
        .memwrite(memwrite), .writedata(writedata), .aluout(aluout),
        .readdata(readdata), .dump_addr(dump_addr), .dump_data(dump_data),
        .state(state), .cycles(cycles)
    );

    // Toy core: {op[4:0], rt[2:0], rs[2:0], imm[4:0]}, JUMP target in [7:0].
    logic [15:0] regs [8];
    logic [7:0]  core_pc;
    logic        core_memwrite;
    logic [15:0] core_aluout, core_writedata;
    logic [2:0]  c_rt, c_rs;
    logic [4:0]  c_imm;
    assign c_rt  = instr[10:8];
    assign c_rs  = instr[7:5];
    assign c_imm = instr[4:0];

    always @(posedge clk) begin
        if (cpu_reset) begin
            core_pc <= 8'd0;
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
        end else begin
            case (instr[15:11])
                T_ADDI:  begin regs[c_rt] <= regs[c_rs] + {11'd0, c_imm}; core_pc <= core_pc + 8'd1; end
                T_LOAD:  begin regs[c_rt] <= readdata; core_pc <= core_pc + 8'd1; end
                T_JUMP:  core_pc <= instr[7:0];
                T_HALT:  core_pc <= core_pc;
                default: core_pc <= core_pc + 8'd1;
            endcase
        end
    end

    always_comb begin
        core_memwrite  = 1'b0;
        core_aluout    = regs[c_rs] + {11'd0, c_imm};
        core_writedata = regs[c_rt];
        if (!cpu_reset && instr[15:11] == T_STORE) core_memwrite = 1'b1;
    end

    logic        man_en, man_memwrite;
    logic [7:0]  man_pc;
    logic [15:0] man_aluout, man_writedata;
    assign pc        = man_en ? man_pc        : core_pc;
    assign memwrite  = man_en ? man_memwrite  : core_memwrite;
    assign aluout    = man_en ? man_aluout    : core_aluout;
    assign writedata = man_en ? man_writedata : core_writedata;

    int errors = 0;
    int checks = 0;
    logic [15:0] mdl_imem [256];
    logic [15:0] mdl_dmem [256];
    bit          mdl_dval [256];

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rt,
                                        input logic [2:0] rs, input logic [4:0] imm);
        return {op, rt, rs, imm};
    endfunction

    // Sequential ISA interpretation of the loaded program from pc 0.
    task automatic ref_run(output int cyc, output bit halted);
        logic [15:0] r [8];
        logic [7:0]  p;
        logic [15:0] w;
        logic [7:0]  a;
        for (int i = 0; i < 8; i++) r[i] = 16'd0;
        p = 8'd0; cyc = 0; halted = 1'b0;
        while (cyc < MAXC && !halted) begin
            w = mdl_imem[p];
            cyc++;
            a = 8'(r[w[7:5]] + {11'd0, w[4:0]});
            case (w[15:11])
                T_HALT:  halted = 1'b1;
                T_ADDI:  begin r[w[10:8]] = r[w[7:5]] + {11'd0, w[4:0]}; p++; end
                T_STORE: begin mdl_dmem[a] = r[w[10:8]]; mdl_dval[a] = 1'b1; p++; end
                T_LOAD:  begin r[w[10:8]] = mdl_dmem[a]; p++; end
                T_JUMP:  p = w[7:0];
                default: p++;
            endcase
        end
    endtask

    task automatic load_word(input logic sel, input logic [7:0] addr, input logic [15:0] data);
        ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
        @(negedge clk);
        ld_valid = 1'b0;
        if (sel) begin mdl_dmem[addr] = data; mdl_dval[addr] = 1'b1; end
        else mdl_imem[addr] = data;
    endtask

    task automatic run_prog(input string name, input bit hold_ld, input bit with_clr);
        int  exp_cyc;
        bit  exp_halt;
        int  n;
        logic [1:0] exp_st;
        ref_run(exp_cyc, exp_halt);
        exp_st = exp_halt ? 2'b10 : 2'b11;
        start = 1'b1; clr = with_clr;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        if (hold_ld) ld_valid = 1'b1;
        for (int i = 0; i < PRESET; i++) begin
            checks++;
            if (state !== 2'b01 || cpu_reset !== 1'b1) begin
                errors++;
                $display("FAIL %s_preset%0d: state=%b cpu_reset=%b, expected 01/1", name, i, state, cpu_reset);
            end
            @(negedge clk);
        end
        checks++;
        if (state !== 2'b01 || cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL %s_run_entry: state=%b cpu_reset=%b, expected 01/0", name, state, cpu_reset);
        end
        n = 0;
        while (state === 2'b01 && n < 64) begin
            checks++;
            if (ld_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_ld_ready_run: got %b expected 0", name, ld_ready);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (state !== exp_st) begin
            errors++;
            $display("FAIL %s_end_state: got %b expected %b", name, state, exp_st);
        end
        checks++;
        if (cycles !== 16'(exp_cyc)) begin
            errors++;
            $display("FAIL %s_cycles: got %0d expected %0d", name, cycles, exp_cyc);
        end
        checks++;
        if (ld_ready !== 1'b1 || cpu_reset !== 1'b0 || instr !== 16'h0800) begin
            errors++;
            $display("FAIL %s_end_outputs: ld_ready=%b cpu_reset=%b instr=%h expected 1/0/0800", name, ld_ready, cpu_reset, instr);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        checks++;
        if (cycles !== 16'(exp_cyc)) begin
            errors++;
            $display("FAIL %s_cycles_frozen: got %0d expected %0d", name, cycles, exp_cyc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 2'b00 || cpu_reset !== 1'b1 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: state=%b cpu_reset=%b ld_ready=%b expected 00/1/1", state, cpu_reset, ld_ready);
        end
        checks++;
        if (cycles !== 16'd0 || instr !== 16'h0800 || dump_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: cycles=%0d instr=%h dump=%h expected 0/0800/0000", cycles, instr, dump_data);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 2'b00 || cpu_reset !== 1'b1 || cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_release: state=%b cpu_reset=%b cycles=%0d expected 00/1/0", state, cpu_reset, cycles);
        end
    endtask

    task automatic test_basic_program;
        load_word(1'b0, 8'd0, 16'h9905);
        load_word(1'b0, 8'd1, 16'h9101);
        load_word(1'b0, 8'd2, 16'hD800);
        run_prog("basic", 1'b0, 1'b0);
        dump_addr = 8'd1;
        @(negedge clk);
        checks++;
        if (dump_data !== mdl_dmem[1] || dump_data !== 16'h0005) begin
            errors++;
            $display("FAIL basic_dump1: got %h expected %h", dump_data, mdl_dmem[1]);
        end
    endtask

    task automatic test_memwrite_ignored;
        man_en = 1'b1; man_pc = 8'd0; man_memwrite = 1'b1;
        man_aluout = 16'h0001; man_writedata = 16'h1234;
        repeat (2) @(negedge clk);
        checks++;
        if (readdata !== mdl_dmem[1]) begin
            errors++;
            $display("FAIL halted_memwrite_readdata: got %h expected %h", readdata, mdl_dmem[1]);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (state !== 2'b00 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL clr_to_idle: state=%b cpu_reset=%b expected 00/1", state, cpu_reset);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        dump_addr = 8'd1;
        @(negedge clk);
        checks++;
        if (state !== 2'b00 || dump_data !== mdl_dmem[1]) begin
            errors++;
            $display("FAIL idle_memwrite_dump: state=%b dump=%h expected 00/%h", state, dump_data, mdl_dmem[1]);
        end
        man_en = 1'b0; man_memwrite = 1'b0;
    endtask

    task automatic test_timeout;
        load_word(1'b0, 8'd0, enc(T_JUMP, 3'd0, 3'd0, 5'd0));
        run_prog("timeout", 1'b0, 1'b0);
    endtask

    task automatic test_halt_priority;
        for (int k = 0; k < MAXC - 1; k++) load_word(1'b0, 8'(k), enc(T_ADDI, 3'd2, 3'd2, 5'd1));
        load_word(1'b0, 8'(MAXC - 1), enc(T_HALT, 3'd0, 3'd0, 5'd0));
        run_prog("halt_prio", 1'b0, 1'b1);
    endtask

    task automatic test_loader_blocked;
        int n;
        load_word(1'b1, 8'd5, 16'h1111);
        n = int'($urandom_range(3, 8));
        for (int k = 0; k < n; k++)
            load_word(1'b0, 8'(k), enc(T_ADDI, 3'($urandom_range(1, 7)), 3'($urandom_range(0, 7)), 5'($urandom)));
        load_word(1'b0, 8'(n), enc(T_HALT, 3'd0, 3'd0, 5'd0));
        ld_sel = 1'b1; ld_addr = 8'd5; ld_data = 16'hBEEF; dump_addr = 8'd5;
        run_prog("ldblock", 1'b1, 1'b0);
        checks++;
        if (dump_data !== 16'h1111) begin
            errors++;
            $display("FAIL ldblock_old_data: got %h expected 1111", dump_data);
        end
        @(negedge clk);
        mdl_dmem[5] = 16'hBEEF;
        checks++;
        if (dump_data !== mdl_dmem[5]) begin
            errors++;
            $display("FAIL ldblock_accepted: got %h expected %h", dump_data, mdl_dmem[5]);
        end
    endtask

    task automatic test_random_programs;
        int n;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) load_word(1'b1, 8'(i), 16'($urandom));
        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(1, 12));
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 2))
                    0:       load_word(1'b0, 8'(k), enc(T_ADDI,  3'($urandom_range(1, 7)), 3'($urandom), 5'($urandom)));
                    1:       load_word(1'b0, 8'(k), enc(T_STORE, 3'($urandom), 3'($urandom), 5'($urandom)));
                    default: load_word(1'b0, 8'(k), enc(T_LOAD,  3'($urandom_range(1, 7)), 3'($urandom), 5'($urandom)));
                endcase
            end
            load_word(1'b0, 8'(n), enc(T_HALT, 3'd0, 3'd0, 5'd0));
            run_prog("random", 1'b0, 1'b0);
            man_en = 1'b1; man_memwrite = 1'b0; man_pc = 8'd0;
            for (int j = 0; j < 8; j++) begin
                a = 8'($urandom);
                man_aluout = {8'($urandom), a};
                #1;
                checks++;
                if (readdata !== mdl_dmem[a]) begin
                    errors++;
                    $display("FAIL random_readdata[%0d]: got %h expected %h", a, readdata, mdl_dmem[a]);
                end
                @(negedge clk);
            end
            man_en = 1'b0;
            for (int k = 0; k < 256; k++) begin
                dump_addr = 8'(k);
                @(negedge clk);
                if (mdl_dval[k]) begin
                    checks++;
                    if (dump_data !== mdl_dmem[k]) begin
                        errors++;
                        $display("FAIL random_dump[%0d]: got %h expected %h", k, dump_data, mdl_dmem[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_midrun_reset;
        int n;
        for (int k = 0; k < 10; k++) load_word(1'b0, 8'(k), enc(T_ADDI, 3'd1, 3'd1, 5'd1));
        load_word(1'b0, 8'd10, enc(T_STORE, 3'd1, 3'd0, 5'd9));
        load_word(1'b0, 8'd11, enc(T_HALT, 3'd0, 3'd0, 5'd0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cycles !== 16'd7 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cycles !== 16'd7 || state !== 2'b01) begin
            errors++;
            $display("FAIL midrun_reach7: cycles=%0d state=%b expected 7/01", cycles, state);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 2'b00 || cpu_reset !== 1'b1 || cycles !== 16'd0) begin
            errors++;
            $display("FAIL midrun_async_reset: state=%b cpu_reset=%b cycles=%0d expected 00/1/0", state, cpu_reset, cycles);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_prog("after_reset", 1'b0, 1'b0);
        dump_addr = 8'd9;
        @(negedge clk);
        checks++;
        if (dump_data !== mdl_dmem[9] || dump_data !== 16'd10) begin
            errors++;
            $display("FAIL after_reset_dump9: got %h expected %h", dump_data, mdl_dmem[9]);
        end
        dump_addr = 8'd5;
        @(negedge clk);
        checks++;
        if (dump_data !== mdl_dmem[5]) begin
            errors++;
            $display("FAIL after_reset_dump5: got %h expected %h", dump_data, mdl_dmem[5]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < 256; i++) mdl_dval[i] = 1'b0;
        ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = 8'd0; ld_data = 16'd0;
        start = 1'b0; clr = 1'b0; dump_addr = 8'd0;
        man_en = 1'b0; man_memwrite = 1'b0; man_pc = 8'd0;
        man_aluout = 16'd0; man_writedata = 16'd0;
        test_reset();
        test_basic_program();
        test_memwrite_ignored();
        test_timeout();
        test_halt_priority();
        test_loader_blocked();
        test_random_programs();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
